bias_load_ctrl: RTL and testbench

Sequencer for the 10-entry local bias memory. It accepts a bias-load command, then streams 16-bit bias words from the upstream loader into consecutive bias addresses. After loading, it serves paired-read requests from the conv/FC datapath, returning two biases packed into 32 bits with a fixed 1-cycle latency. It is the only master of the bias memory port, so loads and reads can never collide.

---
 rtl/bias_pkg.sv | 15 +
 rtl/bias_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_bias_load_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_pkg.sv
// Shared constants and state type for the local bias memory and its load/read sequencer.
// The memory and the controller both import this package, so they always agree on depth.
package bias_pkg;

    localparam int unsigned MAX_BIAS = 10;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } bias_state_t;

endpackage

// File: rtl/bias_load_ctrl.sv
// Bias memory sequencer: streams a configured number of bias words into the memory,
// then serves paired reads {bias[2p+1], bias[2p]} with one cycle of latency.
module bias_load_ctrl #(
    parameter int unsigned MAX_BIAS = bias_pkg::MAX_BIAS,
    parameter int unsigned DATA_W   = bias_pkg::DATA_W,
    parameter int unsigned ADDR_W   = bias_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_bias_num,
    output logic                  cfg_err,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  load_done,
    output logic                  busy,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_pair_idx,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [2*DATA_W-1:0]   rd_data,
    output logic                  rd_err,
    output logic                  mem_write_signal,
    output logic                  mem_read_signal,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_write_data,
    input  logic [2*DATA_W-1:0]   mem_read_data
);

    import bias_pkg::*;

    localparam logic [ADDR_W-1:0] MAX_NUM = ADDR_W'(MAX_BIAS);

    bias_state_t           state_q, state_d;
    logic [ADDR_W-1:0]     num_q, num_d;
    logic [ADDR_W-1:0]     wc_q, wc_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  load_done_q, load_done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_err_q, rd_err_d;
    logic [2*DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                  cfg_ok;
    logic                  last_beat;
    logic [ADDR_W:0]       pair_lo;
    logic [ADDR_W:0]       num_ext;
    logic                  pair_ok;
    logic                  odd_tail;

    assign cfg_ok    = (cfg_bias_num != '0) && (cfg_bias_num <= MAX_NUM);
    assign last_beat = (wc_q == (num_q - 1'b1));

    // Pair bounds are evaluated one bit wider so 2p cannot overflow for large indices.
    assign pair_lo  = {rd_pair_idx, 1'b0};
    assign num_ext  = {1'b0, num_q};
    assign pair_ok  = (pair_lo < num_ext);
    assign odd_tail = ({rd_pair_idx, 1'b1} == num_ext);

    always_comb begin
        state_d          = state_q;
        num_d            = num_q;
        wc_d             = wc_q;
        cfg_err_d        = 1'b0;
        load_done_d      = 1'b0;
        rd_valid_d       = 1'b0;
        rd_err_d         = 1'b0;
        rd_data_d        = rd_data_q;
        in_ready         = 1'b0;
        busy             = 1'b0;
        rd_ready         = 1'b0;
        mem_write_signal = 1'b0;
        mem_read_signal  = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;

        case (state_q)
            IDLE, READY: begin
                // A configuration pulse always takes priority over a same-cycle read.
                if (state_q == READY) begin
                    rd_ready = !cfg_start;
                end
                if (cfg_start) begin
                    if (cfg_ok) begin
                        num_d   = cfg_bias_num;
                        wc_d    = '0;
                        state_d = LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if ((state_q == READY) && rd_req) begin
                    rd_valid_d = 1'b1;
                    if (pair_ok) begin
                        mem_read_signal = 1'b1;
                        mem_addr        = rd_pair_idx;
                        rd_data_d       = odd_tail ?
                                          {{DATA_W{1'b0}}, mem_read_data[DATA_W-1:0]} :
                                          mem_read_data;
                    end else begin
                        rd_err_d  = 1'b1;
                        rd_data_d = '0;
                    end
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    mem_write_signal = 1'b1;
                    mem_addr         = wc_q;
                    mem_write_data   = in_data;
                    wc_d             = wc_q + 1'b1;
                    if (last_beat) begin
                        state_d     = READY;
                        load_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            num_q       <= '0;
            wc_q        <= '0;
            cfg_err_q   <= 1'b0;
            load_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            wc_q        <= wc_d;
            cfg_err_q   <= cfg_err_d;
            load_done_q <= load_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign cfg_err   = cfg_err_q;
    assign load_done = load_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Self-checking bench for bias_load_ctrl: a behavioural bias memory on the port, directed
// tables, multi-cycle corner sequences and randomized load/read traffic against a reference.
module tb_bias_load_ctrl;
    import bias_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  cfg_start;
    logic [ADDR_W-1:0]     cfg_bias_num;
    logic                  cfg_err;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  load_done;
    logic                  busy;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_pair_idx;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [2*DATA_W-1:0]   rd_data;
    logic                  rd_err;
    logic                  mem_write_signal;
    logic                  mem_read_signal;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_write_data;
    logic [2*DATA_W-1:0]   mem_read_data;

    bias_load_ctrl #(.MAX_BIAS(MAX_BIAS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_bias_num     (cfg_bias_num),
        .cfg_err          (cfg_err),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .load_done        (load_done),
        .busy             (busy),
        .rd_req           (rd_req),
        .rd_pair_idx      (rd_pair_idx),
        .rd_ready         (rd_ready),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_err           (rd_err),
        .mem_write_signal (mem_write_signal),
        .mem_read_signal  (mem_read_signal),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bias memory: registered writes, combinational paired read.
    logic [DATA_W-1:0] bmem [MAX_BIAS];
    int                wr_cnt = 0;
    int                ra;

    always @(posedge clk) begin
        if (mem_write_signal) begin
            wr_cnt <= wr_cnt + 1;
            if (int'(mem_addr) < MAX_BIAS) bmem[mem_addr] <= mem_write_data;
        end
    end

    always_comb begin
        mem_read_data = '0;
        ra = 2 * int'(mem_addr);
        if (ra + 1 < MAX_BIAS) mem_read_data = {bmem[ra+1], bmem[ra]};
    end

    // Reference: what the loader has been told, independent of the DUT.
    logic [DATA_W-1:0] exp_mem [MAX_BIAS];
    int                exp_num = 0;
    int                n_cmp = 0;
    int                n_bad = 0;

    typedef struct {
        logic [ADDR_W-1:0]   p;
        logic [2*DATA_W-1:0] data;
        logic                err;
    } rd_vec_t;

    typedef struct {
        logic [ADDR_W-1:0]   num;
        logic                err;
    } cfg_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_pair(input int p, output logic [31:0] d, output logic e);
        int tp;
        tp = 2 * p;
        d  = '0;
        e  = 1'b0;
        if (tp >= exp_num) begin
            e = 1'b1;
        end else begin
            d[15:0]  = exp_mem[tp];
            d[31:16] = (tp + 1 < exp_num) ? exp_mem[tp+1] : 16'h0;
        end
    endfunction

    task automatic do_cfg(input logic [ADDR_W-1:0] n);
        bit ok;
        int w0;
        ok = (n >= 1) && (n <= MAX_BIAS);
        w0 = wr_cnt;
        cfg_start    = 1'b1;
        cfg_bias_num = n;
        step();
        cfg_start = 1'b0;
        #1;
        chk("cfg_err_pulse", cfg_err, !ok);
        chk("busy_after_cfg", busy, ok);
        if (ok) begin
            exp_num = int'(n);
        end else begin
            step();
            chk("cfg_err_clear", cfg_err, 0);
            chk("no_write_on_bad_cfg", wr_cnt, w0);
        end
    endtask

    // gap: 0 = back-to-back, 1 = one idle cycle before every beat, 2 = random 0..2 idles
    task automatic load_words(input int n, input int gap, input logic [DATA_W-1:0] base,
                              input bit rnd);
        int g;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            g = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                #1;
                chk("no_write_in_gap", mem_write_signal, 0);
                chk("in_ready_load", in_ready, 1);
                step();
            end
            d = rnd ? DATA_W'($urandom) : DATA_W'(base + DATA_W'(i));
            in_valid = 1'b1;
            in_data  = d;
            #1;
            chk("wr_signal", mem_write_signal, 1);
            chk("wr_addr", mem_addr, i);
            chk("wr_data", mem_write_data, d);
            chk("load_done_early", load_done, 0);
            exp_mem[i] = d;
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("load_done", load_done, 1);
        chk("busy_after_load", busy, 0);
        chk("in_ready_after_load", in_ready, 0);
        step();
        chk("load_done_clear", load_done, 0);
    endtask

    task automatic check_rd(input int p);
        logic [31:0] d;
        logic        e;
        ref_pair(p, d, e);
        chk("rd_valid", rd_valid, 1);
        chk("rd_err", rd_err, e);
        chk("rd_data", rd_data, d);
    endtask

    task automatic read_burst(input int ps[$]);
        logic [31:0] d;
        logic        e;
        for (int k = 0; k < ps.size(); k++) begin
            rd_req      = 1'b1;
            rd_pair_idx = ADDR_W'(ps[k]);
            #1;
            ref_pair(ps[k], d, e);
            chk("rd_ready", rd_ready, 1);
            chk("mem_read_signal", mem_read_signal, !e);
            step();
            check_rd(ps[k]);
        end
        rd_req = 1'b0;
        step();
        chk("rd_valid_clear", rd_valid, 0);
    endtask

    cfg_vec_t cfg_tab[3];
    rd_vec_t  rd_tab[6];

    initial begin
        int w0;
        int ps[$];

        cfg_tab[0] = '{num: 16'd0,     err: 1'b1};
        cfg_tab[1] = '{num: 16'd11,    err: 1'b1};
        cfg_tab[2] = '{num: 16'hFFFF,  err: 1'b1};

        rd_tab[0] = '{p: 16'd0,     data: 32'h0011_0010, err: 1'b0};
        rd_tab[1] = '{p: 16'd1,     data: 32'h0013_0012, err: 1'b0};
        rd_tab[2] = '{p: 16'd2,     data: 32'h0000_0014, err: 1'b0};
        rd_tab[3] = '{p: 16'd3,     data: 32'h0000_0000, err: 1'b1};
        rd_tab[4] = '{p: 16'd5,     data: 32'h0000_0000, err: 1'b1};
        rd_tab[5] = '{p: 16'hFFFF,  data: 32'h0000_0000, err: 1'b1};

        rst = 1'b0; cfg_start = 1'b0; cfg_bias_num = '0; in_valid = 1'b0;
        in_data = '0; rd_req = 1'b0; rd_pair_idx = '0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_wr", mem_write_signal, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        step();

        // Out-of-range counts from IDLE: error pulse, no writes, still IDLE.
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            cfg_start = 1'b1; cfg_bias_num = cfg_tab[i].num;
            step();
            cfg_start = 1'b0;
            #1;
            chk("tab_cfg_err", cfg_err, cfg_tab[i].err);
            chk("tab_cfg_idle_busy", busy, 0);
            chk("tab_cfg_idle_rd_ready", rd_ready, 0);
            step();
        end
        chk("tab_cfg_no_writes", wr_cnt, w0);

        // Full-depth load 1..10, then the last pair.
        do_cfg(16'd10);
        load_words(10, 0, 16'h0001, 1'b0);
        rd_req = 1'b1; rd_pair_idx = 16'd4;
        step();
        rd_req = 1'b0;
        chk("full_pair4_valid", rd_valid, 1);
        chk("full_pair4_data", rd_data, 32'h000A_0009);

        // Odd count, table of reads including the tail and out-of-range indices.
        do_cfg(16'd5);
        load_words(5, 0, 16'h0010, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rd_req = 1'b1; rd_pair_idx = rd_tab[i].p;
            #1;
            chk("tab_rd_mem_read", mem_read_signal, !rd_tab[i].err);
            step();
            rd_req = 1'b0;
            chk("tab_rd_valid", rd_valid, 1);
            chk("tab_rd_err", rd_err, rd_tab[i].err);
            chk("tab_rd_data", rd_data, rd_tab[i].data);
            step();
        end

        // Bad count in READY keeps READY; cfg_start during LOAD is ignored.
        do_cfg(16'd0);
        chk("ready_kept_rd_ready", rd_ready, 1);
        do_cfg(16'd7);
        cfg_start = 1'b1; cfg_bias_num = 16'd2;
        step();
        cfg_start = 1'b0;
        #1;
        chk("cfg_in_load_no_err", cfg_err, 0);
        chk("cfg_in_load_busy", busy, 1);
        load_words(7, 1, 16'h0, 1'b1);
        ps = '{0, 1, 2, 3, 4};
        read_burst(ps);

        // cfg_start beats a same-cycle read; then back-to-back reads.
        cfg_start = 1'b1; cfg_bias_num = 16'd6; rd_req = 1'b1; rd_pair_idx = 16'd0;
        #1;
        chk("collide_rd_ready", rd_ready, 0);
        chk("collide_no_mem_read", mem_read_signal, 0);
        step();
        cfg_start = 1'b0; rd_req = 1'b0;
        #1;
        chk("collide_no_rd_valid", rd_valid, 0);
        chk("collide_busy", busy, 1);
        exp_num = 6;
        load_words(6, 0, 16'h0, 1'b1);
        ps = '{0, 1, 2};
        read_burst(ps);

        // Randomized loads and reads against the reference.
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_cfg(($urandom_range(0, 1) == 0) ? 16'd0 : ADDR_W'($urandom_range(11, 40)));
            end
            do_cfg(ADDR_W'($urandom_range(1, MAX_BIAS)));
            load_words(exp_num, 2, 16'h0, 1'b1);
            ps.delete();
            for (int k = 0; k < 8; k++) ps.push_back(int'($urandom_range(0, 6)));
            read_burst(ps);
        end

        // Reset in the middle of a load (after 3 beats).
        do_cfg(16'd8);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = DATA_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        step();
        rst = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'hBEEF;
            #1;
            chk("midrst_no_write", mem_write_signal, 0);
            step();
        end
        in_valid = 1'b0;
        chk("midrst_wr_cnt", wr_cnt, w0);
        chk("midrst_idle_rd_ready", rd_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
